mem_access_unit: RTL and testbench
==================================

Name: mem_access_unit

Overview:
- Memory-side stage directly downstream of the multicycle control FSM.
- Consumes its IRWrite, AddrSrc and MemWrite strobes and runs one handshaked access per request on a variable-latency word-wide memory bus.
- Latches fetched instructions into IR/OldPC and load data, sign- or zero-extended, into the Data register. Generates byte strobes for stores.
- Asserts stall so the control FSM holds its state until the access completes.

Parameters:
- XLEN, 32, datapath and address width.
- TIMEOUT, 15, max BUSY cycles without mem_ack before abort (1..255).

Ports:
- clk  in  1  clock
- reset  in  1  reset, asynchronous, active-high
- ir_write  in  1  fetch request, address = pc
- addr_src  in  1  data request, address = alu_result
- mem_write  in  1  data request is a store (valid with addr_src)
- funct3  in  3  access size/sign for data requests
- pc  in  XLEN  current PC
- alu_result  in  XLEN  data address
- write_data  in  XLEN  store data (rs2)
- mem_req  out  1  bus request
- mem_we  out  1  bus write
- mem_addr  out  XLEN  word-aligned bus address
- mem_be  out  4  byte enables
- mem_wdata  out  XLEN  lane-replicated store data
- mem_rdata  in  XLEN  read data, valid with mem_ack
- mem_ack  in  1  access complete
- instr  out  XLEN  instruction register
- old_pc  out  XLEN  PC of instr
- data  out  XLEN  extended load data
- stall  out  1  hold control FSM
- misaligned  out  1  one-cycle pulse: access dropped, bad alignment
- bus_error  out  1  one-cycle pulse: access aborted on timeout

Behaviour:
- Reset: state IDLE. mem_req, mem_we, stall, misaligned and bus_error are 0. mem_be, mem_addr, mem_wdata, instr, old_pc and data are 0. Timeout counter is 0.
- Start condition in IDLE: start = ir_write | addr_src. ir_write has priority; both high means a fetch.
- Capture on the start edge: kind (fetch/load/store), address, funct3 and write_data are latched. Inputs are ignored while BUSY.
- FSM states:
  - IDLE: on start and aligned -> BUSY. On start and misaligned -> IDLE with misaligned=1 for the next cycle and no bus activity.
  - BUSY: mem_req=1; mem_addr, mem_we, mem_be and mem_wdata are held stable. On mem_ack -> IDLE and update registers on that edge. On counter==TIMEOUT-1 with no ack -> IDLE, bus_error=1 next cycle, no register update.
- stall (combinational) = (IDLE & start & aligned) | (BUSY & ~mem_ack). The control FSM advances on the same edge that captures data. Minimum access is 2 cycles (request cycle plus ack in the first BUSY cycle).
- Alignment rules:
  - Fetch requires pc[1:0]==0.
  - lh/lhu/sh require addr[0]==0.
  - lw/sw require addr[1:0]==0.
  - lb/lbu/sb are always aligned.
  - funct3 011/110/111 are treated as word access.
- mem_addr = {addr[XLEN-1:2], 2'b00}.
- mem_be:
  - fetch / word: 1111
  - byte: 0001 << addr[1:0]
  - half: 0011 << {addr[1], 0}
  - mem_be is also driven for loads.
- mem_wdata:
  - sb: {4{wd[7:0]}}
  - sh: {2{wd[15:0]}}
  - sw: wd
- On ack, per access kind:
  - Fetch: instr <= mem_rdata; old_pc <= latched pc.
  - Load: lane = mem_rdata >> (8*addr[1:0]).
    - lb: sign-extend lane[7:0].
    - lbu: zero-extend lane[7:0].
    - lh: sign-extend lane[15:0].
    - lhu: zero-extend lane[15:0].
    - lw: full word.
    - Result goes to data.
  - Store: instr, old_pc and data are unchanged.
- Timeout counter clears on entering BUSY and increments each BUSY cycle without ack.
- A late mem_ack arriving in IDLE is ignored.
- Reset mid-access: immediate return to IDLE; mem_req drops asynchronously; no register update.

Decomposition:
- Shared package holds:
  - access-kind enum (FETCH, LOAD, STORE)
  - FSM state encoding (IDLE, BUSY)
  - funct3 constants (F3_B=000, F3_H=001, F3_W=010, F3_BU=100, F3_HU=101)
- One natural sub-module: load_extend (combinational lane select and sign/zero extension from rdata, addr[1:0], funct3). Reused later by a cache path.

Test Plan:
- Fetch, pc=0x100, ack after 3 cycles with rdata=0x00500093 -> mem_addr=0x100, mem_be=1111, mem_req held 3 cycles, stall high 4 cycles, then instr=0x00500093, old_pc=0x100.
- lb at alu_result=0x203, rdata=0x80FFFFFF, ack immediate -> mem_be=1000, data=0xFFFFFF80. Repeat as lbu -> data=0x00000080.
- sh at 0x302, write_data=0x1234ABCD -> mem_we=1, mem_be=1100, mem_wdata=0xABCDABCD, mem_addr=0x300, data unchanged.
- lw at 0x206 -> no mem_req, misaligned=1 for exactly one cycle, stall low, data unchanged.
- Fetch with no ack, TIMEOUT=15 -> mem_req high 15 cycles, then low, bus_error pulse, stall released, instr unchanged. A late ack 2 cycles later has no effect.
- ir_write and addr_src both high -> fetch performed. Reset asserted in the second BUSY cycle -> mem_req=0 and stall=0 immediately, outputs return to reset values.

Source files
------------

// File: rtl/mem_access_unit_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | mem_access_unit_pkg                                                        |
// | Shared types and helpers for the memory access stage: access kind, FSM     |
// | state encoding, funct3 size codes, alignment check and byte-enable decode. |
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
package mem_access_unit_pkg;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    LOAD  = 2'd1,
    STORE = 2'd2
  } access_kind_e;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_e;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  // Size decode from funct3: bit 1 set means word (covers 010/011/110/111),
  // otherwise bit 0 selects half versus byte.
  function automatic logic addr_aligned(input access_kind_e kind,
                                        input logic [2:0]   f3,
                                        input logic [1:0]   off);
    logic ok;
    if (kind == FETCH || f3[1]) ok = (off == 2'b00);
    else if (f3[0])             ok = ~off[0];
    else                        ok = 1'b1;
    return ok;
  endfunction

  function automatic logic [3:0] byte_enable(input access_kind_e kind,
                                             input logic [2:0]   f3,
                                             input logic [1:0]   off);
    logic [3:0] be;
    if (kind == FETCH || f3[1]) be = 4'b1111;
    else if (f3[0])             be = 4'b0011 << {off[1], 1'b0};
    else                        be = 4'b0001 << off;
    return be;
  endfunction

endpackage
`default_nettype wire

// File: rtl/mem_access_unit_load_extend.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | mem_access_unit_load_extend                                                |
// | Selects the addressed byte/half lane of a bus read word and sign- or       |
// | zero-extends it according to funct3. Purely combinational.                |
// | Ports: rdata_i  - bus read word                                            |
// |        off_i    - byte offset within the word (addr[1:0])                 |
// |        funct3_i - load size/sign code                                     |
// |        data_o   - extended load result                                    |
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
module mem_access_unit_load_extend
  import mem_access_unit_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] rdata_i,
  input  logic [1:0]      off_i,
  input  logic [2:0]      funct3_i,
  output logic [XLEN-1:0] data_o
);

  logic [XLEN-1:0] w_lane;

  always_comb begin
    w_lane = rdata_i >> {off_i, 3'b000};
    case (funct3_i)
      F3_B:    data_o = {{(XLEN-8){w_lane[7]}},   w_lane[7:0]};
      F3_BU:   data_o = {{(XLEN-8){1'b0}},        w_lane[7:0]};
      F3_H:    data_o = {{(XLEN-16){w_lane[15]}}, w_lane[15:0]};
      F3_HU:   data_o = {{(XLEN-16){1'b0}},       w_lane[15:0]};
      F3_W:    data_o = w_lane;
      default: data_o = w_lane;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/mem_access_unit.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | mem_access_unit                                                            |
// | Memory-side stage behind the multicycle control FSM. Runs one handshaked   |
// | bus access per IRWrite/AddrSrc request, latches fetched instructions into  |
// | IR/OldPC and extended load data into Data, and stalls the control FSM      |
// | until the access completes, is dropped (misaligned) or times out.          |
// | Ports: clk, reset (async, active-high)                                     |
// |        ir_write_i/addr_src_i/mem_write_i/funct3_i - request strobes        |
// |        pc_i/alu_result_i/write_data_i             - address and store data|
// |        mem_*_o/mem_rdata_i/mem_ack_i               - word-wide memory bus  |
// |        instr_o/old_pc_o/data_o                     - architectural regs    |
// |        stall_o/misaligned_o/bus_error_o            - status to control     |
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
module mem_access_unit
  import mem_access_unit_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int TIMEOUT = 15
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            ir_write_i,
  input  logic            addr_src_i,
  input  logic            mem_write_i,
  input  logic [2:0]      funct3_i,
  input  logic [XLEN-1:0] pc_i,
  input  logic [XLEN-1:0] alu_result_i,
  input  logic [XLEN-1:0] write_data_i,
  output logic            mem_req_o,
  output logic            mem_we_o,
  output logic [XLEN-1:0] mem_addr_o,
  output logic [3:0]      mem_be_o,
  output logic [XLEN-1:0] mem_wdata_o,
  input  logic [XLEN-1:0] mem_rdata_i,
  input  logic            mem_ack_i,
  output logic [XLEN-1:0] instr_o,
  output logic [XLEN-1:0] old_pc_o,
  output logic [XLEN-1:0] data_o,
  output logic            stall_o,
  output logic            misaligned_o,
  output logic            bus_error_o
);

  logic            w_start;
  access_kind_e    w_kind;
  logic [XLEN-1:0] w_addr;
  logic            w_aligned;
  logic [3:0]      w_be;
  logic [XLEN-1:0] w_wdata;
  logic [XLEN-1:0] w_load_data;

  state_e          state_q;
  access_kind_e    kind_q;
  logic [2:0]      f3_q;
  logic [1:0]      off_q;
  logic [XLEN-1:0] pc_q;
  logic [7:0]      cnt_q;
  logic            mem_req_q;
  logic            mem_we_q;
  logic [XLEN-1:0] mem_addr_q;
  logic [3:0]      mem_be_q;
  logic [XLEN-1:0] mem_wdata_q;
  logic [XLEN-1:0] instr_q;
  logic [XLEN-1:0] old_pc_q;
  logic [XLEN-1:0] data_q;
  logic            misaligned_q;
  logic            bus_error_q;

  // Request decode; a fetch wins when both strobes are present.
  always_comb begin
    w_start = ir_write_i | addr_src_i;
    if (ir_write_i)       w_kind = FETCH;
    else if (mem_write_i) w_kind = STORE;
    else                  w_kind = LOAD;
    w_addr    = ir_write_i ? pc_i : alu_result_i;
    w_aligned = addr_aligned(w_kind, funct3_i, w_addr[1:0]);
    w_be      = byte_enable(w_kind, funct3_i, w_addr[1:0]);
    // Store data is replicated into every lane so the byte enables alone
    // select what the memory writes.
    w_wdata = '0;
    if (w_kind == STORE) begin
      if (funct3_i[1])      w_wdata = write_data_i;
      else if (funct3_i[0]) w_wdata = {(XLEN/16){write_data_i[15:0]}};
      else                  w_wdata = {(XLEN/8){write_data_i[7:0]}};
    end
  end

  mem_access_unit_load_extend #(
    .XLEN(XLEN)
  ) u_load_extend (
    .rdata_i  (mem_rdata_i),
    .off_i    (off_q),
    .funct3_i (f3_q),
    .data_o   (w_load_data)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      kind_q       <= FETCH;
      f3_q         <= '0;
      off_q        <= '0;
      pc_q         <= '0;
      cnt_q        <= '0;
      mem_req_q    <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_be_q     <= '0;
      mem_wdata_q  <= '0;
      instr_q      <= '0;
      old_pc_q     <= '0;
      data_q       <= '0;
      misaligned_q <= 1'b0;
      bus_error_q  <= 1'b0;
    end else begin
      misaligned_q <= 1'b0;
      bus_error_q  <= 1'b0;
      case (state_q)
        IDLE: begin
          if (w_start) begin
            if (w_aligned) begin
              state_q     <= BUSY;
              kind_q      <= w_kind;
              f3_q        <= funct3_i;
              off_q       <= w_addr[1:0];
              pc_q        <= pc_i;
              cnt_q       <= '0;
              mem_req_q   <= 1'b1;
              mem_we_q    <= (w_kind == STORE);
              mem_addr_q  <= {w_addr[XLEN-1:2], 2'b00};
              mem_be_q    <= w_be;
              mem_wdata_q <= w_wdata;
            end else begin
              misaligned_q <= 1'b1;
            end
          end
        end
        BUSY: begin
          if (mem_ack_i) begin
            state_q   <= IDLE;
            mem_req_q <= 1'b0;
            mem_we_q  <= 1'b0;
            case (kind_q)
              FETCH: begin
                instr_q  <= mem_rdata_i;
                old_pc_q <= pc_q;
              end
              LOAD:    data_q <= w_load_data;
              default: ;
            endcase
          end else if (cnt_q == 8'(TIMEOUT - 1)) begin
            state_q     <= IDLE;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            bus_error_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q + 8'd1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Combinational so the control FSM advances on the same edge that
  // captures the returned data.
  assign stall_o = ((state_q == IDLE) & w_start & w_aligned)
                 | ((state_q == BUSY) & ~mem_ack_i);

  assign mem_req_o    = mem_req_q;
  assign mem_we_o     = mem_we_q;
  assign mem_addr_o   = mem_addr_q;
  assign mem_be_o     = mem_be_q;
  assign mem_wdata_o  = mem_wdata_q;
  assign instr_o      = instr_q;
  assign old_pc_o     = old_pc_q;
  assign data_o       = data_q;
  assign misaligned_o = misaligned_q;
  assign bus_error_o  = bus_error_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_access_unit.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_mem_access_unit                                                         |
// | Scoreboard bench for mem_access_unit: every request pushes its expected    |
// | bus fields and register contents; a monitor pops on completion.            |
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
module tb_mem_access_unit;

  localparam int XLEN    = 32;
  localparam int TIMEOUT = 15;

  localparam logic [1:0] OUT_OK  = 2'd0;
  localparam logic [1:0] OUT_MIS = 2'd1;
  localparam logic [1:0] OUT_TMO = 2'd2;

  logic            clk = 1'b0;
  logic            reset;
  logic            ir_write, addr_src, mem_write;
  logic [2:0]      funct3;
  logic [XLEN-1:0] pc, alu_result, write_data;
  logic            mem_req, mem_we;
  logic [XLEN-1:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]      mem_be;
  logic            mem_ack;
  logic [XLEN-1:0] instr, old_pc, data;
  logic            stall, misaligned, bus_error;

  mem_access_unit #(
    .XLEN(XLEN),
    .TIMEOUT(TIMEOUT)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .ir_write_i   (ir_write),
    .addr_src_i   (addr_src),
    .mem_write_i  (mem_write),
    .funct3_i     (funct3),
    .pc_i         (pc),
    .alu_result_i (alu_result),
    .write_data_i (write_data),
    .mem_req_o    (mem_req),
    .mem_we_o     (mem_we),
    .mem_addr_o   (mem_addr),
    .mem_be_o     (mem_be),
    .mem_wdata_o  (mem_wdata),
    .mem_rdata_i  (mem_rdata),
    .mem_ack_i    (mem_ack),
    .instr_o      (instr),
    .old_pc_o     (old_pc),
    .data_o       (data),
    .stall_o      (stall),
    .misaligned_o (misaligned),
    .bus_error_o  (bus_error)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  outcome;
    logic [31:0] addr;
    logic [3:0]  be;
    logic        we;
    logic [31:0] wdata;
    logic [31:0] instr;
    logic [31:0] old_pc;
    logic [31:0] data;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic check_regs(input exp_t e);
    check("instr", instr, e.instr);
    check("old_pc", old_pc, e.old_pc);
    check("data", data, e.data);
  endtask

  // Monitor: bus fields every request cycle, registers one edge after the
  // ack handshake, and register preservation on misaligned/bus_error pulses.
  exp_t mon_e;
  logic mon_pending = 1'b0;
  always @(negedge clk) begin
    if (reset) begin
      mon_pending = 1'b0;
    end else begin
      if (mon_pending) begin
        mon_pending = 1'b0;
        if (sb.size() == 0) check("sb_underflow", 32'd1, 32'd0);
        else begin
          mon_e = sb.pop_front();
          check("done_outcome", 32'(OUT_OK), 32'(mon_e.outcome));
          check_regs(mon_e);
        end
      end
      if (misaligned || bus_error) begin
        if (sb.size() == 0) check("sb_underflow", 32'd1, 32'd0);
        else begin
          mon_e = sb.pop_front();
          check("abort_outcome", 32'(misaligned ? OUT_MIS : OUT_TMO), 32'(mon_e.outcome));
          check("abort_req", 32'(mem_req), 32'd0);
          check_regs(mon_e);
        end
      end
      if (mem_req && sb.size() != 0) begin
        check("bus_addr", mem_addr, sb[0].addr);
        check("bus_be", 32'(mem_be), 32'(sb[0].be));
        check("bus_we", 32'(mem_we), 32'(sb[0].we));
        if (sb[0].we) check("bus_wdata", mem_wdata, sb[0].wdata);
      end
      if (mem_req && mem_ack) mon_pending = 1'b1;
    end
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // One request cycle, then lat BUSY cycles without ack and one with ack.
  task automatic access(input exp_t e, input logic fetch, input logic store,
                        input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] wd, input logic [31:0] rd, input int lat);
    int stall_cnt;
    int req_cnt;
    stall_cnt = 0;
    req_cnt   = 0;
    sb.push_back(e);
    ir_write   = fetch;
    addr_src   = !fetch;
    mem_write  = store;
    funct3     = f3;
    write_data = wd;
    if (fetch) pc = a;
    else       alu_result = a;
    @(negedge clk);
    if (stall) stall_cnt++;
    @(posedge clk);
    #1;
    ir_write  = 1'b0;
    addr_src  = 1'b0;
    mem_write = 1'b0;
    mem_rdata = rd;
    for (int i = 0; i <= lat; i++) begin
      mem_ack = (i == lat);
      @(negedge clk);
      if (stall) stall_cnt++;
      if (mem_req && !mem_ack) req_cnt++;
      @(posedge clk);
      #1;
    end
    mem_ack = 1'b0;
    check("stall_cycles", 32'(stall_cnt), 32'(lat + 1));
    check("req_wait", 32'(req_cnt), 32'(lat));
    idle(2);
    check("sb_drain", 32'(sb.size()), 32'd0);
  endtask

  initial begin
    int mis_cnt, req_cnt, err_cnt, stall_cnt;
    reset = 1'b1;
    ir_write = 1'b0; addr_src = 1'b0; mem_write = 1'b0; funct3 = 3'b000;
    pc = '0; alu_result = '0; write_data = '0; mem_rdata = '0; mem_ack = 1'b0;
    idle(2);
    reset = 1'b0;
    @(negedge clk);
    check("rst_req", 32'(mem_req), 32'd0);
    check("rst_we", 32'(mem_we), 32'd0);
    check("rst_stall", 32'(stall), 32'd0);
    check("rst_misaligned", 32'(misaligned), 32'd0);
    check("rst_bus_error", 32'(bus_error), 32'd0);
    check("rst_be", 32'(mem_be), 32'd0);
    check("rst_addr", mem_addr, 32'd0);
    check("rst_wdata", mem_wdata, 32'd0);
    check("rst_instr", instr, 32'd0);
    check("rst_old_pc", old_pc, 32'd0);
    check("rst_data", data, 32'd0);
    @(posedge clk);
    #1;

    //            outcome addr        be       we    wdata         instr         old_pc     data
    access('{OUT_OK, 32'h100, 4'b1111, 1'b0, 32'h0,        32'h00500093, 32'h100, 32'h0},
           1'b1, 1'b0, 3'b000, 32'h100, 32'h0, 32'h00500093, 3);
    access('{OUT_OK, 32'h200, 4'b1000, 1'b0, 32'h0,        32'h00500093, 32'h100, 32'hFFFFFF80},
           1'b0, 1'b0, 3'b000, 32'h203, 32'h0, 32'h80FFFFFF, 0);
    access('{OUT_OK, 32'h200, 4'b1000, 1'b0, 32'h0,        32'h00500093, 32'h100, 32'h00000080},
           1'b0, 1'b0, 3'b100, 32'h203, 32'h0, 32'h80FFFFFF, 0);
    access('{OUT_OK, 32'h300, 4'b1100, 1'b1, 32'hABCDABCD, 32'h00500093, 32'h100, 32'h00000080},
           1'b0, 1'b1, 3'b001, 32'h302, 32'h1234ABCD, 32'hFFFFFFFF, 1);
    access('{OUT_OK, 32'h200, 4'b1100, 1'b0, 32'h0,        32'h00500093, 32'h100, 32'hFFFF8001},
           1'b0, 1'b0, 3'b001, 32'h202, 32'h0, 32'h80010000, 2);
    access('{OUT_OK, 32'h200, 4'b0011, 1'b0, 32'h0,        32'h00500093, 32'h100, 32'h0000F00F},
           1'b0, 1'b0, 3'b101, 32'h200, 32'h0, 32'h1234F00F, 0);
    access('{OUT_OK, 32'h204, 4'b1111, 1'b0, 32'h0,        32'h00500093, 32'h100, 32'hDEADBEEF},
           1'b0, 1'b0, 3'b010, 32'h204, 32'h0, 32'hDEADBEEF, 1);
    access('{OUT_OK, 32'h100, 4'b0010, 1'b1, 32'h55555555, 32'h00500093, 32'h100, 32'hDEADBEEF},
           1'b0, 1'b1, 3'b000, 32'h101, 32'h00000055, 32'h0, 0);
    access('{OUT_OK, 32'h010, 4'b1111, 1'b1, 32'hCAFEF00D, 32'h00500093, 32'h100, 32'hDEADBEEF},
           1'b0, 1'b1, 3'b010, 32'h010, 32'hCAFEF00D, 32'h0, 2);
    access('{OUT_OK, 32'h104, 4'b1111, 1'b0, 32'h0,        32'h00A00113, 32'h104, 32'hDEADBEEF},
           1'b1, 1'b0, 3'b000, 32'h104, 32'h0, 32'h00A00113, 0);

    // Misaligned lw: dropped, one-cycle pulse, no bus activity, no stall.
    sb.push_back('{OUT_MIS, 32'h0, 4'b0, 1'b0, 32'h0, 32'h00A00113, 32'h104, 32'hDEADBEEF});
    addr_src = 1'b1; funct3 = 3'b010; alu_result = 32'h206;
    @(negedge clk);
    check("mis_stall", 32'(stall), 32'd0);
    @(posedge clk);
    #1;
    addr_src = 1'b0;
    mis_cnt = 0; req_cnt = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (misaligned) mis_cnt++;
      if (mem_req) req_cnt++;
      @(posedge clk);
      #1;
    end
    check("mis_pulse_cycles", 32'(mis_cnt), 32'd1);
    check("mis_req_cycles", 32'(req_cnt), 32'd0);
    check("sb_drain", 32'(sb.size()), 32'd0);

    // Fetch that is never acknowledged: aborted after TIMEOUT BUSY cycles.
    sb.push_back('{OUT_TMO, 32'h40, 4'b1111, 1'b0, 32'h0, 32'h00A00113, 32'h104, 32'hDEADBEEF});
    ir_write = 1'b1; pc = 32'h40;
    @(posedge clk);
    #1;
    ir_write = 1'b0;
    req_cnt = 0; err_cnt = 0; stall_cnt = 0;
    for (int i = 0; i < TIMEOUT + 2; i++) begin
      @(negedge clk);
      if (mem_req) req_cnt++;
      if (bus_error) err_cnt++;
      if (stall) stall_cnt++;
      @(posedge clk);
      #1;
    end
    check("tmo_req_cycles", 32'(req_cnt), 32'(TIMEOUT));
    check("tmo_err_cycles", 32'(err_cnt), 32'd1);
    check("tmo_stall_cycles", 32'(stall_cnt), 32'(TIMEOUT));
    // Late ack two cycles after the bus_error pulse must be ignored.
    mem_rdata = 32'hBAD0BAD0;
    mem_ack = 1'b1;
    @(negedge clk);
    check("late_ack_stall", 32'(stall), 32'd0);
    @(posedge clk);
    #1;
    mem_ack = 1'b0;
    idle(1);
    @(negedge clk);
    check("late_ack_req", 32'(mem_req), 32'd0);
    check("late_ack_instr", instr, 32'h00A00113);
    check("sb_drain", 32'(sb.size()), 32'd0);
    @(posedge clk);
    #1;

    // Both strobes: fetch wins; then reset in the second BUSY cycle.
    sb.push_back('{OUT_OK, 32'h80, 4'b1111, 1'b0, 32'h0, 32'h0, 32'h0, 32'h0});
    ir_write = 1'b1; addr_src = 1'b1; mem_write = 1'b1; funct3 = 3'b010;
    pc = 32'h80; alu_result = 32'h999;
    @(negedge clk);
    check("both_stall", 32'(stall), 32'd1);
    @(posedge clk);
    #1;
    ir_write = 1'b0; addr_src = 1'b0; mem_write = 1'b0;
    @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    check("rst_mid_req", 32'(mem_req), 32'd0);
    check("rst_mid_stall", 32'(stall), 32'd0);
    check("rst_mid_instr", instr, 32'd0);
    check("rst_mid_old_pc", old_pc, 32'd0);
    check("rst_mid_data", data, 32'd0);
    check("rst_mid_be", 32'(mem_be), 32'd0);
    check("rst_mid_addr", mem_addr, 32'd0);
    sb.delete();
    @(posedge clk);
    #1;
    reset = 1'b0;
    idle(3);
    @(negedge clk);
    check("post_rst_req", 32'(mem_req), 32'd0);
    check("post_rst_stall", 32'(stall), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
